rotate_unit: RTL

ROTATE_UNIT -- requirements
Module: rotate_unit

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/rotate_step.sv | 48 ++++
 rtl/rotate_unit.sv | 135 +++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU package: global CPU defines plus the rotate unit's op and FSM enums.
package cpu_pkg;

    // Native datapath width of the CPU.
    localparam int CPU_XLEN = 32;

    // Rotate operation encoding, matching the 2-bit op port.
    typedef enum logic [1:0] {
        OP_ROL = 2'd0,
        OP_ROR = 2'd1,
        OP_RCL = 2'd2,
        OP_RCR = 2'd3
    } rot_op_e;

    // Rotate unit sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } rot_state_e;

endpackage : cpu_pkg

// File: rtl/rotate_step.sv
// Combinational rotate of one RUN step: rotates data (and carry for RCL/RCR)
// by i_step bits, where i_step is at most STEP_MAX.
module rotate_step
    import cpu_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int AMT_W    = 5,
    parameter int STEP_MAX = 1
) (
    input  rot_op_e            i_op,
    input  logic [WIDTH-1:0]   i_data,
    input  logic               i_carry,
    input  logic [AMT_W-1:0]   i_step,
    output logic [WIDTH-1:0]   o_data,
    output logic               o_carry
);

    logic [WIDTH-1:0] w_d;
    logic             w_c;

    // Apply up to STEP_MAX single-bit rotations; positions beyond i_step pass through.
    always_comb begin
        // NOTE: blocking assignments here are intentional - each loop pass
        // must see the value produced by the previous pass.
        w_d = i_data;
        w_c = i_carry;
        for (int i = 0; i < STEP_MAX; i++) begin
            if (i < int'(i_step)) begin
                case (i_op)
                    OP_ROL: begin
                        w_d = {w_d[WIDTH-2:0], w_d[WIDTH-1]};
                        w_c = w_d[0];
                    end
                    OP_ROR: begin
                        w_d = {w_d[0], w_d[WIDTH-1:1]};
                        w_c = w_d[WIDTH-1];
                    end
                    // The carry is the extra MSB of a (WIDTH+1)-bit ring.
                    OP_RCL:  {w_c, w_d} = {w_d, w_c};
                    default: {w_c, w_d} = {w_d[0], w_c, w_d[WIDTH-1:1]};
                endcase
            end
        end
        o_data  = w_d;
        o_carry = w_c;
    end

endmodule : rotate_step

// File: rtl/rotate_unit.sv
// Multi-cycle rotate unit (ROL/ROR/RCL/RCR) with IDLE/RUN/DONE sequencer.
// Define ROTATE_UNIT_MULTI_STEP_EN to rotate up to 4 bits per cycle instead of 1;
// results are identical in both builds, only latency changes.
module rotate_unit
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int AMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   operand_a,
    input  logic [AMT_W-1:0]   amount,
    input  logic               carry_in,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result,
    output logic               carry_out
);

`ifdef ROTATE_UNIT_MULTI_STEP_EN
    localparam int STEP_MAX = 4;
`else
    localparam int STEP_MAX = 1;
`endif

    rot_state_e         r_state;
    rot_state_e         w_state_next;
    rot_op_e            r_op;
    logic [WIDTH-1:0]   r_data;
    logic               r_carry;
    logic [AMT_W-1:0]   r_remaining;
    logic [WIDTH-1:0]   r_result;
    logic               r_carry_out;

    logic               w_accept;
    logic               w_last;
    logic [AMT_W-1:0]   w_step;
    logic [WIDTH-1:0]   w_step_data;
    logic               w_step_carry;

    // Bits to rotate this cycle: the smaller of what is left and STEP_MAX.
    assign w_step = (r_remaining > AMT_W'(STEP_MAX)) ? AMT_W'(STEP_MAX) : r_remaining;

    rotate_step #(
        .WIDTH    (WIDTH),
        .AMT_W    (AMT_W),
        .STEP_MAX (STEP_MAX)
    ) u_step (
        .i_op    (r_op),
        .i_data  (r_data),
        .i_carry (r_carry),
        .i_step  (w_step),
        .o_data  (w_step_data),
        .o_carry (w_step_carry)
    );

    // Next-state logic: accept start in IDLE/DONE, count down in RUN; enable low freezes everything.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        if (enable) begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        w_accept     = 1'b1;
                        w_state_next = (amount == '0) ? ST_DONE : ST_RUN;
                    end else if (r_state == ST_DONE) begin
                        w_state_next = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    w_last = (w_step == r_remaining);
                    if (w_last) begin
                        w_state_next = ST_DONE;
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Operand capture, per-step rotation and result latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op        <= OP_ROL;
            r_data      <= '0;
            r_carry     <= 1'b0;
            r_remaining <= '0;
            r_result    <= '0;
            r_carry_out <= 1'b0;
        end else if (enable) begin
            if (w_accept) begin
                r_op        <= rot_op_e'(op);
                r_data      <= operand_a;
                r_carry     <= carry_in;
                r_remaining <= amount;
                if (amount == '0) begin
                    r_result    <= operand_a;
                    r_carry_out <= carry_in;
                end
            end else if (r_state == ST_RUN) begin
                r_data      <= w_step_data;
                r_carry     <= w_step_carry;
                // Saturating decrement: the counter never wraps below zero.
                r_remaining <= (r_remaining >= w_step) ? (r_remaining - w_step) : '0;
                if (w_last) begin
                    r_result    <= w_step_data;
                    r_carry_out <= w_step_carry;
                end
            end
        end
    end

    assign busy      = (r_state == ST_RUN);
    assign done      = (r_state == ST_DONE);
    assign result    = r_result;
    assign carry_out = r_carry_out;

endmodule : rotate_unit
